alu_multicycle: RTL and testbench

- Parametrised, handshaked successor to the combinational CPU ALU.
- Executes the eight 3-bit ALU ops (ADD/SUB/MUL/DIV/AND/OR/XOR/NOT):
  - logic/add/sub ops in one cycle;
  - MUL (shift-add) and DIV (restoring) iteratively.
- Sits between decode (opcode to ALU op mapping unchanged) and writeback.
- Decode stalls on in_ready; writeback consumes via out_valid/out_ready.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_iter_muldiv.sv | 94 +++++++++
 rtl/alu_multicycle.sv | 151 +++++++++++++++
 tb/tb_alu_multicycle.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_pkg;

   // ALU operation encoding; the decode-side mapping depends on these values.
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_MUL = 3'b010,
      ALU_DIV = 3'b011,
      ALU_AND = 3'b100,
      ALU_OR  = 3'b101,
      ALU_XOR = 3'b110,
      ALU_NOT = 3'b111
   } aluop_t;

   // Control states of the top-level handshake FSM.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } alu_state_t;

   // Bit positions inside the flags output.
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: shift-add multiply and restoring divide, one step per cycle.
// On the final step, done is high and result carries that step's outcome, so
// the caller can register it on the same edge.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] cnt_r;
   logic             is_div_r;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quot_r;
   logic [WIDTH-1:0] divisor_r;

   logic [WIDTH-1:0] acc_nxt_s;
   logic [WIDTH:0]   rem_sh_s;
   logic [WIDTH-1:0] rem_nxt_s;
   logic [WIDTH-1:0] quot_nxt_s;

   // Next-step values for both algorithms; only the active one is committed.
   always_comb begin
      acc_nxt_s  = acc_r;
      rem_sh_s   = {rem_r, quot_r[WIDTH-1]};
      rem_nxt_s  = rem_sh_s[WIDTH-1:0];
      quot_nxt_s = {quot_r[WIDTH-2:0], 1'b0};
      if (mplier_r[0]) begin
         acc_nxt_s = acc_r + mcand_r;
      end else begin
         acc_nxt_s = acc_r;
      end
      // The shifted remainder may need WIDTH+1 bits; the difference always fits in WIDTH.
      if (rem_sh_s >= {1'b0, divisor_r}) begin
         rem_nxt_s  = rem_sh_s[WIDTH-1:0] - divisor_r;
         quot_nxt_s = {quot_r[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt_s  = rem_sh_s[WIDTH-1:0];
         quot_nxt_s = {quot_r[WIDTH-2:0], 1'b0};
      end
   end

   assign busy   = (cnt_r != {CNT_W{1'b0}});
   assign done   = (cnt_r == CNT_W'(1));
   assign result = is_div_r ? quot_nxt_s : acc_nxt_s;

   // Load operands on start, then advance one iteration per cycle while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= {CNT_W{1'b0}};
         is_div_r  <= 1'b0;
         mcand_r   <= {WIDTH{1'b0}};
         mplier_r  <= {WIDTH{1'b0}};
         acc_r     <= {WIDTH{1'b0}};
         rem_r     <= {WIDTH{1'b0}};
         quot_r    <= {WIDTH{1'b0}};
         divisor_r <= {WIDTH{1'b0}};
      end else if (start) begin
         cnt_r     <= CNT_W'(WIDTH);
         is_div_r  <= is_div;
         mcand_r   <= a;
         mplier_r  <= b;
         acc_r     <= {WIDTH{1'b0}};
         rem_r     <= {WIDTH{1'b0}};
         quot_r    <= a;
         divisor_r <= b;
      end else if (busy) begin
         cnt_r <= cnt_r - CNT_W'(1);
         if (is_div_r) begin
            rem_r  <= rem_nxt_s;
            quot_r <= quot_nxt_s;
         end else begin
            acc_r    <= acc_nxt_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/add/sub ops, iterative MUL/DIV.
// Owns the IDLE/BUSY/DONE FSM, the valid/ready handshakes and flag generation.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       flags,
   output logic             div_zero
);

   alu_state_t       state_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] result_r;
   logic [1:0]       flags_r;
   logic             div_zero_r;

   aluop_t           op_s;
   logic             accept_s;
   logic             start_s;
   logic             b_zero_s;
   logic [WIDTH-1:0] single_res_s;
   logic             iter_busy_s;
   logic             iter_done_s;
   logic [WIDTH-1:0] iter_result_s;

   // Z and N derived from a final result value.
   function automatic logic [1:0] flags_of(input logic [WIDTH-1:0] v);
      logic [1:0] f;
      f         = 2'b00;
      f[FLAG_Z] = (v == {WIDTH{1'b0}});
      f[FLAG_N] = v[WIDTH-1];
      return f;
   endfunction

   assign op_s     = aluop_t'(op);
   assign accept_s = in_valid && in_ready_r;
   assign b_zero_s = (b == {WIDTH{1'b0}});

   // Launch the iterative engine only for MUL and for DIV with a nonzero divisor.
   always_comb begin
      start_s = 1'b0;
      if (accept_s && (op_s == ALU_MUL)) begin
         start_s = 1'b1;
      end else if (accept_s && (op_s == ALU_DIV) && !b_zero_s) begin
         start_s = 1'b1;
      end else begin
         start_s = 1'b0;
      end
   end

   // Results of the ops that complete on the accept edge (DIV here covers only b==0).
   always_comb begin
      single_res_s = {WIDTH{1'b0}};
      case (op_s)
         ALU_ADD: single_res_s = a + b;
         ALU_SUB: single_res_s = a - b;
         ALU_AND: single_res_s = a & b;
         ALU_OR:  single_res_s = a | b;
         ALU_XOR: single_res_s = a ^ b;
         ALU_NOT: single_res_s = ~a;
         ALU_DIV: single_res_s = {WIDTH{1'b1}};
         default: single_res_s = {WIDTH{1'b0}};
      endcase
   end

   alu_iter_muldiv #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_s),
      .is_div (op_s == ALU_DIV),
      .a      (a),
      .b      (b),
      .busy   (iter_busy_s),
      .done   (iter_done_s),
      .result (iter_result_s)
   );

   // Handshake FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         flags_r     <= 2'b10;
         div_zero_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r    <= BUSY;
                  in_ready_r <= 1'b0;
                  div_zero_r <= 1'b0;
               end else if (accept_s) begin
                  state_r     <= DONE;
                  in_ready_r  <= 1'b0;
                  out_valid_r <= 1'b1;
                  result_r    <= single_res_s;
                  flags_r     <= flags_of(single_res_s);
                  div_zero_r  <= (op_s == ALU_DIV);
               end
            end
            BUSY: begin
               if (iter_done_s) begin
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
                  result_r    <= iter_result_s;
                  flags_r     <= flags_of(iter_result_s);
               end else if (!iter_busy_s) begin
                  // Engine idle while we wait on it: recover instead of hanging.
                  state_r    <= IDLE;
                  in_ready_r <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign flags     = flags_r;
   assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: expected {div_zero, flags, result}
// are pushed to a scoreboard queue at issue and popped when out_valid appears.
module tb_alu_multicycle;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [1:0]   flags;
   logic         div_zero;

   int errors = 0;
   int checks = 0;
   logic [W+2:0] sb[$];

   alu_multicycle #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: {div_zero, Z, N, result}.
   function automatic logic [W+2:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      logic         dz;
      dz = 1'b0;
      case (o)
         3'd0: r = x + y;
         3'd1: r = x - y;
         3'd2: r = x * y;
         3'd3: begin
            if (y == 32'd0) begin
               r  = 32'hFFFF_FFFF;
               dz = 1'b1;
            end else begin
               r = x / y;
            end
         end
         3'd4: r = x & y;
         3'd5: r = x | y;
         3'd6: r = x ^ y;
         default: r = ~x;
      endcase
      return {dz, (r == 32'd0), r[W-1], r};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request, wait for acceptance, push expectation; returns at cycle 1 after accept.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int guard;
      guard = 0;
      op = o; a = x; b = y; in_valid = 1'b1;
      while (!in_ready && guard < 200) begin
         step();
         guard++;
      end
      step();
      in_valid = 1'b0;
      sb.push_back(model(o, x, y));
   endtask

   // Wait for out_valid; lat is the cycle count after accept (1 = cycle right after).
   task automatic wait_out(output int lat, output int ready_low);
      lat = 1;
      ready_low = 0;
      while (!out_valid && lat < 100) begin
         if (!in_ready) ready_low++;
         step();
         lat++;
      end
      if (!in_ready) ready_low++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 3'd0; a = 32'd0; b = 32'd0;
      #12;
      checks++;
      if ({in_ready, out_valid, result, flags, div_zero} !== {1'b1, 1'b0, 32'd0, 2'b10, 1'b0}) begin
         errors++;
         $display("FAIL reset: got rdy=%b vld=%b res=%h flg=%b dz=%b", in_ready, out_valid, result, flags, div_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_add_wrap();
      int lat, rl;
      logic [W+2:0] exp_v;
      issue(3'd0, 32'hFFFF_FFFF, 32'd1);
      wait_out(lat, rl);
      exp_v = sb.pop_front();
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d need 1", lat); end
      checks++;
      if ({div_zero, flags, result} !== exp_v) begin
         errors++; $display("FAIL add_wrap: got %h need %h", {div_zero, flags, result}, exp_v);
      end
      step();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++; $display("FAIL add_ready_after: got rdy=%b vld=%b need rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_sub_not();
      int lat, rl;
      logic [W+2:0] exp_v;
      issue(3'd1, 32'd5, 32'd7);
      wait_out(lat, rl);
      exp_v = sb.pop_front();
      checks++;
      if ({div_zero, flags, result} !== {1'b0, 2'b01, 32'hFFFF_FFFE}) begin
         errors++; $display("FAIL sub: got %h need %h", {div_zero, flags, result}, {1'b0, 2'b01, 32'hFFFF_FFFE});
      end
      step();
      issue(3'd7, 32'hFFFF_FFFF, 32'h1234_5678);
      wait_out(lat, rl);
      exp_v = sb.pop_front();
      checks++;
      if ({div_zero, flags, result} !== exp_v) begin
         errors++; $display("FAIL not: got %h need %h", {div_zero, flags, result}, exp_v);
      end
      step();
   endtask

   task automatic test_mul();
      int lat, rl;
      logic [W+2:0] exp_v;
      issue(3'd2, 32'h0001_0001, 32'h0001_0001);
      wait_out(lat, rl);
      exp_v = sb.pop_front();
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d need 33", lat); end
      checks++;
      if ({div_zero, flags, result} !== {1'b0, 2'b00, 32'h0002_0001}) begin
         errors++; $display("FAIL mul: got %h need %h", {div_zero, flags, result}, exp_v);
      end
      step();
      checks++;
      if (rl !== 33 || in_ready !== 1'b1) begin
         errors++; $display("FAIL mul_ready_low: got %0d cycles low, rdy=%b need 33 and 1", rl, in_ready);
      end
   endtask

   task automatic test_div();
      int lat, rl;
      logic [W+2:0] exp_v;
      issue(3'd3, 32'd100, 32'd7);
      wait_out(lat, rl);
      exp_v = sb.pop_front();
      checks++;
      if (lat !== 33 || {div_zero, flags, result} !== {1'b0, 2'b00, 32'd14}) begin
         errors++; $display("FAIL div: got lat=%0d %h need lat=33 %h", lat, {div_zero, flags, result}, exp_v);
      end
      step();
      issue(3'd3, 32'd9, 32'd0);
      wait_out(lat, rl);
      exp_v = sb.pop_front();
      checks++;
      if (lat !== 1 || {div_zero, flags, result} !== {1'b1, 2'b01, 32'hFFFF_FFFF}) begin
         errors++; $display("FAIL div_zero: got lat=%0d %h need lat=1 %h", lat, {div_zero, flags, result}, exp_v);
      end
      step();
   endtask

   task automatic test_backpressure();
      int lat, rl;
      logic [W+2:0] exp_v;
      out_ready = 1'b0;
      issue(3'd0, 32'd3, 32'd4);
      wait_out(lat, rl);
      exp_v = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7)); in_valid = ~in_valid;
         step();
         checks++;
         if (out_valid !== 1'b1 || {div_zero, flags, result} !== exp_v) begin
            errors++; $display("FAIL bp_hold: cycle %0d got vld=%b %h need 1 %h", i, out_valid, {div_zero, flags, result}, exp_v);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_handoff: got vld=%b need 0", out_valid); end
      step(); step();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++; $display("FAIL bp_no_extra: got vld=%b rdy=%b need 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_mul();
      int lat, rl;
      logic [W+2:0] exp_v;
      issue(3'd2, 32'hDEAD_BEEF, 32'h0000_1234);
      for (int i = 0; i < 9; i++) step();
      rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      checks++;
      if ({in_ready, out_valid, result, flags, div_zero} !== {1'b1, 1'b0, 32'd0, 2'b10, 1'b0}) begin
         errors++; $display("FAIL mid_reset: got rdy=%b vld=%b res=%h flg=%b dz=%b", in_ready, out_valid, result, flags, div_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      issue(3'd0, 32'd2, 32'd2);
      wait_out(lat, rl);
      exp_v = sb.pop_front();
      checks++;
      if (lat !== 1 || {div_zero, flags, result} !== {1'b0, 2'b00, 32'd4}) begin
         errors++; $display("FAIL post_reset_add: got lat=%0d %h need lat=1 %h", lat, {div_zero, flags, result}, exp_v);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int lat, rl;
      int need_lat;
      logic [2:0] o;
      logic [W-1:0] x, y;
      logic [W+2:0] exp_v;
      for (int i = 0; i < 16; i++) begin
         o = 3'(i % 8);
         x = $urandom;
         y = (i == 11) ? 32'd0 : ((i % 4 == 3) ? 32'($urandom_range(1, 1000)) : $urandom);
         need_lat = (o == 3'd2 || (o == 3'd3 && y != 32'd0)) ? 33 : 1;
         issue(o, x, y);
         wait_out(lat, rl);
         exp_v = sb.pop_front();
         checks++;
         if (lat !== need_lat || {div_zero, flags, result} !== exp_v) begin
            errors++; $display("FAIL b2b op=%0d a=%h b=%h: got lat=%0d %h need lat=%0d %h", o, x, y, lat, {div_zero, flags, result}, need_lat, exp_v);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_sub_not();
      test_mul();
      test_div();
      test_backpressure();
      test_reset_mid_mul();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
